// File: rtl/hm01b0_pkg.sv
// Shared geometry defaults and pixel type for the HM01B0 sensor output model.
package hm01b0_pkg;

    localparam int HM01B0_WIDTH   = 320;
    localparam int HM01B0_HEIGHT  = 240;
    localparam int HM01B0_H_BLANK = 80;
    localparam int HM01B0_V_BLANK = 10;

    typedef logic [7:0] pixel_t;

endpackage

// File: rtl/hm01b0_camera_model_if.sv
// Parallel video bus of the HM01B0: pixel clock, pixel byte and the two sync strobes.
interface hm01b0_camera_model_if;
    import hm01b0_pkg::*;

    logic   clock;
    pixel_t pixdata;
    logic   hsync;
    logic   vsync;

    // No handshake: the source pushes one pixel per clock and the sink must keep up.
    // Data and syncs change on the clock falling edge and are sampled on the rising edge.
    modport master (output clock, pixdata, hsync, vsync);
    modport slave  (input  clock, pixdata, hsync, vsync);

endinterface

// File: rtl/hm01b0_timing_gen.sv
// Free-running column/row raster counters with active-area decode and image address.
module hm01b0_timing_gen
    import hm01b0_pkg::*;
#(
    parameter int WIDTH   = HM01B0_WIDTH,
    parameter int HEIGHT  = HM01B0_HEIGHT,
    parameter int H_BLANK = HM01B0_H_BLANK,
    parameter int V_BLANK = HM01B0_V_BLANK
) (
    input  logic                              mclk,
    input  logic                              reset,
    output logic                              active_row,
    output logic                              active_px,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   addr
);

    localparam int LINE_LEN    = WIDTH + H_BLANK;
    localparam int FRAME_LINES = HEIGHT + V_BLANK;
    localparam int COL_W       = $clog2(LINE_LEN);
    localparam int ROW_W       = $clog2(FRAME_LINES);
    localparam int ADDR_W      = $clog2(WIDTH * HEIGHT);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (col == COL_W'(LINE_LEN - 1)) begin
            col <= '0;
            row <= (row == ROW_W'(FRAME_LINES - 1)) ? '0 : row + 1'b1;
        end else begin
            col <= col + 1'b1;
        end
    end

    assign active_row = 32'(row) < 32'(HEIGHT);
    assign active_px  = active_row && (32'(col) < 32'(WIDTH));

    // Only meaningful inside the active area; outside it the value may exceed the image.
    assign addr = ADDR_W'(row) * ADDR_W'(WIDTH) + ADDR_W'(col);

endmodule

// File: rtl/hm01b0_camera_model.sv
// HM01B0 video output model: replays a preloaded grayscale frame with sensor sync timing.
module hm01b0_camera_model
    import hm01b0_pkg::*;
#(
    parameter int WIDTH   = HM01B0_WIDTH,
    parameter int HEIGHT  = HM01B0_HEIGHT,
    parameter int H_BLANK = HM01B0_H_BLANK,
    parameter int V_BLANK = HM01B0_V_BLANK
) (
    input  logic                         mclk,
    input  logic                         reset,
    hm01b0_camera_model_if.master        vid
);

    localparam int ADDR_W = $clog2(WIDTH * HEIGHT);

    // Loaded from outside by hierarchical reference; read-only here.
    pixel_t hm01b0_image [0:WIDTH*HEIGHT-1];

    logic              active_row;
    logic              active_px;
    logic [ADDR_W-1:0] addr;

    hm01b0_timing_gen #(
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .H_BLANK (H_BLANK),
        .V_BLANK (V_BLANK)
    ) u_timing (
        .mclk       (mclk),
        .reset      (reset),
        .active_row (active_row),
        .active_px  (active_px),
        .addr       (addr)
    );

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            vid.vsync   <= 1'b0;
            vid.hsync   <= 1'b0;
            vid.pixdata <= '0;
        end else begin
            vid.vsync   <= active_row;
            vid.hsync   <= active_px;
            vid.pixdata <= active_px ? hm01b0_image[addr] : '0;
        end
    end

    // Outputs move on mclk rise, so consumers get a full half period on the pixel clock rise.
    assign vid.clock = ~mclk;

endmodule

// File: tb/tb_hm01b0_camera_model.sv
// Bench for hm01b0_camera_model on a reduced raster so several frames fit in a short run.
module tb_hm01b0_camera_model;

  localparam int W     = 40;
  localparam int H     = 10;
  localparam int HB    = 8;
  localparam int VB    = 3;
  localparam int LINE  = W + HB;
  localparam int FL    = H + VB;
  localparam int FRAME = FL * LINE;
  localparam int N     = W * H;

  logic mclk = 1'b0;
  logic reset = 1'b1;

  hm01b0_camera_model_if vid ();

  hm01b0_camera_model #(
    .WIDTH   (W),
    .HEIGHT  (H),
    .H_BLANK (HB),
    .V_BLANK (VB)
  ) dut (
    .mclk  (mclk),
    .reset (reset),
    .vid   (vid)
  );

  // clock / reset block
  always #5 mclk = ~mclk;

  logic [7:0] img [N];
  int m_row = 0;
  int m_col = 0;
  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q [$];
  logic       cap_hs [$];
  logic       cap_vs [$];
  logic [7:0] cap_px [$];

  typedef struct {
    int         line;
    int         px;
    logic [7:0] exp_px;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp_v);
    end
  endtask

  // One mclk cycle: push the model's expectation at the edge, compare at the falling edge.
  task automatic step();
    logic [9:0] e;
    logic [9:0] got;
    logic ar, ap;
    @(posedge mclk);
    if (reset) begin
      e = '0;
      m_row = 0;
      m_col = 0;
    end else begin
      ar = (m_row < H);
      ap = ar && (m_col < W);
      e = {ar, ap, ap ? img[m_row * W + m_col] : 8'h00};
      if (m_col == LINE - 1) begin
        m_col = 0;
        m_row = (m_row == FL - 1) ? 0 : m_row + 1;
      end else begin
        m_col = m_col + 1;
      end
    end
    exp_q.push_back(e);
    @(negedge mclk);
    got = {vid.vsync, vid.hsync, vid.pixdata};
    cap_vs.push_back(vid.vsync);
    cap_hs.push_back(vid.hsync);
    cap_px.push_back(vid.pixdata);
    check("scoreboard", 32'(got), 32'(exp_q.pop_front()));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_capture();
    cap_hs.delete();
    cap_vs.delete();
    cap_px.delete();
  endtask

  // Asynchronous assertion between edges; outputs must clear before any clock edge.
  task automatic async_reset_check(input string name);
    #1 reset = 1'b1;
    #1;
    check({name, "_vsync"}, 32'(vid.vsync), 32'd0);
    check({name, "_hsync"}, 32'(vid.hsync), 32'd0);
    check({name, "_pixdata"}, 32'(vid.pixdata), 32'd0);
    run(2);
    reset = 1'b0;
  endtask

  task automatic check_first_line(input string name);
    int run_len;
    check({name, "_first_vsync"}, 32'(cap_vs[0]), 32'd1);
    check({name, "_first_hsync"}, 32'(cap_hs[0]), 32'd1);
    check({name, "_first_pix"}, 32'(cap_px[0]), 32'(img[0]));
    run_len = 0;
    while (run_len < LINE && cap_hs[run_len]) run_len++;
    check({name, "_first_line_len"}, 32'(run_len), 32'(W));
  endtask

  initial begin
    int rises [$];
    int cnt, cnt2, mism, last_fall, vs_fall, waited, r;

    for (int i = 0; i < N; i++) begin
      img[i] = 8'(i);
      dut.hm01b0_image[i] = img[i];
    end

    vecs[0] = '{0, 0, 8'h00};
    vecs[1] = '{0, 39, 8'h27};
    vecs[2] = '{1, 0, 8'h28};
    vecs[3] = '{6, 15, 8'hFF};
    vecs[4] = '{6, 16, 8'h00};
    vecs[5] = '{7, 0, 8'h18};
    vecs[6] = '{9, 39, 8'h8F};

    // Reset held from time zero.
    #12;
    check("reset_vsync", 32'(vid.vsync), 32'd0);
    check("reset_hsync", 32'(vid.hsync), 32'd0);
    check("reset_pixdata", 32'(vid.pixdata), 32'd0);
    run(2);
    reset = 1'b0;

    // Reset mid-line.
    run(17);
    async_reset_check("midline_reset");

    clear_capture();
    run(2 * FRAME + 3 * LINE);
    check_first_line("start");

    for (int v = 0; v < 7; v++) begin
      check($sformatf("vec%0d_hsync", v), 32'(cap_hs[vecs[v].line * LINE + vecs[v].px]), 32'd1);
      check($sformatf("vec%0d_pix", v), 32'(cap_px[vecs[v].line * LINE + vecs[v].px]), 32'(vecs[v].exp_px));
    end

    // Line timing over the first three lines.
    for (int l = 0; l < 3; l++) begin
      cnt = 0;
      cnt2 = 0;
      for (int k = 0; k < LINE; k++) begin
        if (cap_hs[l * LINE + k] != (k < W)) cnt++;
        if (!cap_hs[l * LINE + k] && cap_px[l * LINE + k] != 8'h00) cnt2++;
      end
      check($sformatf("line%0d_hsync_shape", l), 32'(cnt), 32'd0);
      check($sformatf("line%0d_blank_pix_zero", l), 32'(cnt2), 32'd0);
    end

    // Frame timing over the first frame.
    cnt = 0;
    cnt2 = 0;
    mism = 0;
    last_fall = -1;
    vs_fall = -1;
    for (int i = 0; i < FRAME; i++) begin
      if (cap_hs[i] && (i == 0 || !cap_hs[i - 1])) begin
        rises.push_back(i);
        if (cap_vs[i]) cnt++;
      end
      if (!cap_vs[i]) cnt2++;
      if (!cap_vs[i] && cap_hs[i]) mism++;
      if (i > 0 && !cap_hs[i] && cap_hs[i - 1]) last_fall = i;
      if (i > 0 && !cap_vs[i] && cap_vs[i - 1] && vs_fall < 0) vs_fall = i;
    end
    check("rise_spacing_0_1", 32'(rises[1] - rises[0]), 32'(LINE));
    check("rise_spacing_1_2", 32'(rises[2] - rises[1]), 32'(LINE));
    check("hsync_rises_in_vsync", 32'(cnt), 32'(H));
    check("vsync_low_cycles", 32'(cnt2), 32'(VB * LINE));
    check("hsync_in_vblank", 32'(mism), 32'd0);
    check("vsync_fall_cycle", 32'(vs_fall), 32'(H * LINE));
    check("vsync_fall_after_hsync", 32'(vs_fall - last_fall), 32'(HB));
    check("vsync_rise_with_hsync", 32'(cap_vs[FRAME] & cap_hs[FRAME] & ~cap_vs[FRAME - 1]), 32'd1);

    // Second frame must replay the first exactly.
    for (int l = 0; l < FL; l++) begin
      mism = 0;
      for (int k = 0; k < LINE; k++) begin
        if ({cap_vs[FRAME + l * LINE + k], cap_hs[FRAME + l * LINE + k], cap_px[FRAME + l * LINE + k]} !==
            {cap_vs[l * LINE + k], cap_hs[l * LINE + k], cap_px[l * LINE + k]}) mism++;
      end
      check($sformatf("wrap_line%0d", l), 32'(mism), 32'd0);
    end

    // Reset mid-frame at row 5, col 20.
    waited = 0;
    while (!(m_row == 5 && m_col == 20) && waited <= FRAME) begin
      step();
      waited++;
    end
    check("midframe_position_reached", 32'(waited <= FRAME), 32'd1);
    async_reset_check("midframe_reset");
    clear_capture();
    run(2 * LINE);
    check_first_line("after_midframe");
    check("after_midframe_line1_pix", 32'(cap_px[LINE]), 32'(img[W]));

    // Reset at a random raster position.
    r = $urandom_range(1, FRAME - 1);
    run(r);
    async_reset_check("random_reset");
    clear_capture();
    run(LINE + 4);
    check_first_line("after_random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
